// File: rtl/bw_io_jp_pkg.sv
// Shared definitions for the IO-ring JTAG TAP: state encoding and opcodes.
package bw_io_jp_pkg;

    localparam int JP_IR_W = 4;

    // Encoding follows the IEEE 1149.1 state assignment table.
    typedef enum logic [3:0] {
        TAP_EX2DR = 4'h0,
        TAP_EX1DR = 4'h1,
        TAP_SHDR  = 4'h2,
        TAP_PAUDR = 4'h3,
        TAP_SELIR = 4'h4,
        TAP_UPDDR = 4'h5,
        TAP_CAPDR = 4'h6,
        TAP_SELDR = 4'h7,
        TAP_EX2IR = 4'h8,
        TAP_EX1IR = 4'h9,
        TAP_SHIR  = 4'hA,
        TAP_PAUIR = 4'hB,
        TAP_RTI   = 4'hC,
        TAP_UPDIR = 4'hD,
        TAP_CAPIR = 4'hE,
        TAP_TLR   = 4'hF
    } tap_state_e;

    localparam logic [JP_IR_W-1:0] JP_EXTEST = 4'b0000;
    localparam logic [JP_IR_W-1:0] JP_SAMPLE = 4'b0001;
    localparam logic [JP_IR_W-1:0] JP_IDCODE = 4'b0010;
    localparam logic [JP_IR_W-1:0] JP_BYPASS = 4'b1111;

endpackage

// File: rtl/bw_io_jp_tap_fsm.sv
// 16-state TAP sequencer: state register, TMS next-state decode and
// one-hot strobes for the states the datapath acts on.
module bw_io_jp_tap_fsm
    import bw_io_jp_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst_l,
    input  logic       i_tms,
    output tap_state_e o_state,
    output logic       o_tlr,
    output logic       o_capdr,
    output logic       o_shdr,
    output logic       o_upddr,
    output logic       o_capir,
    output logic       o_shir,
    output logic       o_updir
);

    tap_state_e r_state;
    tap_state_e w_next;

    always_ff @(posedge i_tck or negedge i_trst_l) begin
        if (!i_trst_l) begin
            r_state <= TAP_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TAP_TLR:   w_next = i_tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   w_next = i_tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: w_next = i_tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: w_next = i_tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  w_next = i_tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: w_next = i_tms ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: w_next = i_tms ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: w_next = i_tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: w_next = i_tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: w_next = i_tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: w_next = i_tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  w_next = i_tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: w_next = i_tms ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: w_next = i_tms ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: w_next = i_tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: w_next = i_tms ? TAP_SELDR : TAP_RTI;
            default:   w_next = TAP_TLR;
        endcase
    end

    assign o_state = r_state;
    assign o_tlr   = (r_state == TAP_TLR);
    assign o_capdr = (r_state == TAP_CAPDR);
    assign o_shdr  = (r_state == TAP_SHDR);
    assign o_upddr = (r_state == TAP_UPDDR);
    assign o_capir = (r_state == TAP_CAPIR);
    assign o_shir  = (r_state == TAP_SHIR);
    assign o_updir = (r_state == TAP_UPDIR);

endmodule

// File: rtl/bw_io_jp_tap_ctl.sv
// JTAG TAP controller for the IO-ring boundary-scan chain: IR, IDCODE and
// bypass registers, BSR control strobes and the TDO mux.
module bw_io_jp_tap_ctl
    import bw_io_jp_pkg::*;
#(
    parameter int          IR_W   = JP_IR_W,
    parameter logic [31:0] IDCODE = 32'h0000_1FFF
) (
    input  logic            tck,
    input  logic            trst_l,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    output logic            bsr_si,
    input  logic            bsr_so,
    output logic            shift_dr,
    output logic            clock_dr,
    output logic            update_dr,
    output logic            extest,
    output logic [IR_W-1:0] ir_q
);

    localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(JP_EXTEST);
    localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(JP_SAMPLE);
    localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(JP_IDCODE);
    localparam logic [IR_W-1:0] IR_CAPT   = IR_W'(1);

    tap_state_e      w_state;
    logic            w_tlr, w_capdr, w_shdr, w_upddr, w_capir, w_shir, w_updir;
    logic [IR_W-1:0] r_ir_sr;
    logic [IR_W-1:0] r_ir;
    logic [31:0]     r_id_sr;
    logic            r_byp;
    logic            r_tdo, r_tdo_en;
    logic            r_shift_dr, r_clock_dr, r_update_dr;
    logic            w_bsr_sel, w_dr_so, w_tdo_nxt;

    bw_io_jp_tap_fsm u_fsm (
        .i_tck    (tck),
        .i_trst_l (trst_l),
        .i_tms    (tms),
        .o_state  (w_state),
        .o_tlr    (w_tlr),
        .o_capdr  (w_capdr),
        .o_shdr   (w_shdr),
        .o_upddr  (w_upddr),
        .o_capir  (w_capir),
        .o_shir   (w_shir),
        .o_updir  (w_updir)
    );

    // Unknown opcodes fall through to the bypass bit.
    assign w_bsr_sel = (r_ir == OP_EXTEST) || (r_ir == OP_SAMPLE);
    assign w_dr_so   = w_bsr_sel ? bsr_so : ((r_ir == OP_IDCODE) ? r_id_sr[0] : r_byp);

    always_comb begin
        w_tdo_nxt = 1'b0;
        case (w_state)
            TAP_SHIR: w_tdo_nxt = r_ir_sr[0];
            TAP_SHDR: w_tdo_nxt = w_dr_so;
            default:  w_tdo_nxt = 1'b0;
        endcase
    end

    // Shift registers are always recaptured before use, so they carry no reset.
    always_ff @(posedge tck) begin
        if (w_capir) begin
            r_ir_sr <= IR_CAPT;
        end else if (w_shir) begin
            r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
        end
        if (w_capdr) begin
            r_id_sr <= IDCODE;
            r_byp   <= 1'b0;
        end else if (w_shdr) begin
            r_id_sr <= {tdi, r_id_sr[31:1]};
            r_byp   <= tdi;
        end
    end

    always_ff @(negedge tck or negedge trst_l) begin
        if (!trst_l) begin
            r_ir <= OP_IDCODE;
        end else if (w_tlr) begin
            r_ir <= OP_IDCODE;
        end else if (w_updir) begin
            r_ir <= r_ir_sr;
        end
    end

    // Falling-edge launch keeps strobes and TDO stable across the next rising edge.
    always_ff @(negedge tck or negedge trst_l) begin
        if (!trst_l) begin
            r_tdo       <= 1'b0;
            r_tdo_en    <= 1'b0;
            r_clock_dr  <= 1'b0;
            r_shift_dr  <= 1'b0;
            r_update_dr <= 1'b0;
        end else begin
            r_tdo       <= w_tdo_nxt;
            r_tdo_en    <= w_shir | w_shdr;
            r_clock_dr  <= w_bsr_sel & (w_capdr | w_shdr);
            r_shift_dr  <= w_bsr_sel & w_shdr;
            r_update_dr <= w_bsr_sel & w_upddr;
        end
    end

    assign tdo       = r_tdo;
    assign tdo_en    = r_tdo_en;
    assign bsr_si    = tdi;
    assign shift_dr  = r_shift_dr;
    assign clock_dr  = r_clock_dr;
    assign update_dr = r_update_dr;
    assign extest    = (r_ir == OP_EXTEST);
    assign ir_q      = r_ir;

endmodule

// File: tb/tb_bw_io_jp_tap_ctl.sv
// Scoreboard bench for bw_io_jp_tap_ctl with an 8-cell external BSR chain.
module tb_bw_io_jp_tap_ctl;

    localparam logic [31:0] IDC  = 32'h0000_1FFF;
    localparam logic [7:0]  PINS = 8'h3C;

    // Model state numbering: 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PauDR
    // 7 Ex2DR 8 UpdDR 9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PauIR 14 Ex2IR 15 UpdIR
    localparam int S_TLR  = 0;
    localparam int S_CDR  = 3;
    localparam int S_SHDR = 4;
    localparam int S_UDR  = 8;
    localparam int S_CIR  = 10;
    localparam int S_SHIR = 11;
    localparam int S_UIR  = 15;

    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    typedef struct packed {
        logic       tdo;
        logic       tdo_en;
        logic       shift_dr;
        logic       clock_dr;
        logic       update_dr;
        logic       extest;
        logic       bsr_si;
        logic [3:0] ir_q;
    } exp_t;

    logic       tck = 1'b0;
    logic       trst_l = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       bsr_so;
    logic       tdo, tdo_en, bsr_si, shift_dr, clock_dr, update_dr, extest;
    logic [3:0] ir_q;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    exp_t mon_e;

    int         m_st = 0;
    logic [3:0] m_irsr = 4'b0000;
    logic [3:0] m_irq = 4'b0010;
    logic [31:0] m_id = 32'h0;
    logic       m_byp = 1'b0;
    logic [7:0] m_chain = 8'h00;
    logic [7:0] m_latch = 8'h00;

    logic [7:0] env_chain = 8'h00;
    logic [7:0] env_latch = 8'h00;

    always #5 tck = ~tck;

    bw_io_jp_tap_ctl dut (
        .tck       (tck),
        .trst_l    (trst_l),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .bsr_si    (bsr_si),
        .bsr_so    (bsr_so),
        .shift_dr  (shift_dr),
        .clock_dr  (clock_dr),
        .update_dr (update_dr),
        .extest    (extest),
        .ir_q      (ir_q)
    );

    // External boundary-scan cells driven purely by the DUT's strobes.
    always @(posedge tck) begin
        if (clock_dr && !shift_dr) begin
            env_chain <= PINS;
        end else if (clock_dr && shift_dr) begin
            env_chain <= {bsr_si, env_chain[7:1]};
        end
        if (update_dr) begin
            env_latch <= env_chain;
        end
    end
    assign bsr_so = env_chain[0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge tck) begin
        #2;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("tdo",       32'(tdo),       32'(mon_e.tdo));
            chk("tdo_en",    32'(tdo_en),    32'(mon_e.tdo_en));
            chk("shift_dr",  32'(shift_dr),  32'(mon_e.shift_dr));
            chk("clock_dr",  32'(clock_dr),  32'(mon_e.clock_dr));
            chk("update_dr", 32'(update_dr), 32'(mon_e.update_dr));
            chk("extest",    32'(extest),    32'(mon_e.extest));
            chk("bsr_si",    32'(bsr_si),    32'(mon_e.bsr_si));
            chk("ir_q",      32'(ir_q),      32'(mon_e.ir_q));
        end
    end

    // One TCK cycle: drive inputs, advance the reference model, queue the
    // outputs expected after the following falling edge.
    task automatic step(input logic t_tms, input logic t_tdi, input logic t_rst_n);
        exp_t e;
        logic sel;
        @(negedge tck);
        #3;
        tms    = t_tms;
        tdi    = t_tdi;
        trst_l = t_rst_n;
        if (!t_rst_n) begin
            m_st = S_TLR;
        end else begin
            sel = (m_irq == 4'b0000) || (m_irq == 4'b0001);
            if (m_st == S_CIR)  m_irsr = 4'b0001;
            if (m_st == S_SHIR) m_irsr = {t_tdi, m_irsr[3:1]};
            if (m_st == S_CDR) begin
                m_id  = IDC;
                m_byp = 1'b0;
                if (sel) m_chain = PINS;
            end
            if (m_st == S_SHDR) begin
                m_id  = {t_tdi, m_id[31:1]};
                m_byp = t_tdi;
                if (sel) m_chain = {t_tdi, m_chain[7:1]};
            end
            if (m_st == S_UDR && sel) m_latch = m_chain;
            m_st = t_tms ? nx1[m_st] : nx0[m_st];
        end
        if (m_st == S_UIR) m_irq = m_irsr;
        if (m_st == S_TLR) m_irq = 4'b0010;
        sel         = (m_irq == 4'b0000) || (m_irq == 4'b0001);
        e.ir_q      = m_irq;
        e.extest    = (m_irq == 4'b0000);
        e.tdo_en    = (m_st == S_SHIR) || (m_st == S_SHDR);
        e.tdo       = (m_st == S_SHIR) ? m_irsr[0] :
                      (m_st == S_SHDR) ? (sel ? m_chain[0] : (m_irq == 4'b0010) ? m_id[0] : m_byp) :
                      1'b0;
        e.clock_dr  = sel && ((m_st == S_CDR) || (m_st == S_SHDR));
        e.shift_dr  = sel && (m_st == S_SHDR);
        e.update_dr = sel && (m_st == S_UDR);
        e.bsr_si    = t_tdi;
        q.push_back(e);
        @(posedge tck);
    endtask

    // From RTI: load an instruction and return to RTI.
    task automatic load_ir(input logic [3:0] op);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(i == 3, op[i], 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    // From RTI: scan n bits (LSB first) through the selected DR, back to RTI.
    task automatic scan_dr(input logic [63:0] d, input int n);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) step(i == n - 1, d[i], 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);

        step(1'b0, 1'b0, 1'b1);
        scan_dr({32'h0, 32'($urandom)}, 32);

        // Mid-ShDR reset after loading SAMPLE
        load_ir(4'b0001);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);

        // Park in PauIR, then five TMS=1
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b1);

        step(1'b0, 1'b0, 1'b1);
        load_ir(4'b0000);
        scan_dr({56'h0, 8'($urandom)}, 8);
        load_ir(4'b1010);
        scan_dr({56'h0, 8'($urandom)}, 8);
        load_ir(4'b0001);
        scan_dr(64'hA5, 8);
        step(1'b0, 1'b0, 1'b1);
        chk("bsr_latch", 32'(env_latch), 32'h0000_00A5);
        chk("bsr_latch_model", 32'(env_latch), 32'(m_latch));

        repeat (40) begin
            repeat (5) step(1'b1, 1'($urandom), 1'b1);
            step(1'b0, 1'($urandom), 1'b1);
            load_ir(4'($urandom));
            scan_dr({32'($urandom), 32'($urandom)}, int'($urandom_range(1, 40)));
            repeat (20) step($urandom_range(0, 9) < 4, 1'($urandom), $urandom_range(0, 49) != 0);
        end

        repeat (3) @(negedge tck);
        #3;
        chk("sb_drain", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
